conv_punct_encoder: RTL and testbench

//  802.11a TX-side K=7 convolutional encoder with puncturing to rate 1/2, 2/3 or 3/4.

---
 rtl/conv_punct_encoder.sv | 127 ++++++++++++
 tb/tb_conv_punct_encoder.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/conv_punct_encoder.sv
// K=7 convolutional encoder (802.11a, G0=133/G1=171 octal) with puncturing to 1/2, 2/3, 3/4.
// Serial in, serial out, valid/ready on both sides, 2-entry output buffer.
module conv_punct_encoder #(
   parameter logic [6:0] G0 = 7'o133,
   parameter logic [6:0] G1 = 7'o171
) (
   input  logic       iClk,
   input  logic       iRst,
   input  logic       iStart,
   input  logic [1:0] iRate,
   input  logic       iData,
   input  logic       iValid,
   output logic       oReady,
   output logic       oData,
   output logic       oValid,
   input  logic       iReady
);

   typedef enum logic [1:0] {
      RATE_1_2 = 2'b00,
      RATE_2_3 = 2'b01,
      RATE_3_4 = 2'b10
   } rate_t;

   typedef enum logic [1:0] {
      PH0 = 2'd0,
      PH1 = 2'd1,
      PH2 = 2'd2
   } phase_t;

   logic [5:0] r_s;
   phase_t     r_phase;
   rate_t      r_rate;
   logic [1:0] r_buf;
   logic [1:0] r_cnt;

   logic [5:0] w_s_eff, w_s_nxt;
   phase_t     w_phase_eff, w_phase_nxt;
   rate_t      w_rate_eff, w_rate_nxt, w_rate_in;
   logic [1:0] w_buf_nxt, w_cnt_nxt;
   logic [6:0] w_taps;
   logic       w_a, w_b, w_accept, w_pop;

   always_comb begin
      case (iRate)
         2'b01:   w_rate_in = RATE_2_3;
         2'b10:   w_rate_in = RATE_3_4;
         default: w_rate_in = RATE_1_2;
      endcase
   end

   assign oValid   = (r_cnt != 2'd0);
   assign oData    = r_buf[0];
   assign oReady   = (r_cnt == 2'd0) | ((r_cnt == 2'd1) & iReady);
   assign w_accept = iValid & oReady;
   assign w_pop    = oValid & iReady;

   // iStart takes effect on the same edge, so a co-incident bit sees the cleared state
   assign w_s_eff     = iStart ? '0 : r_s;
   assign w_phase_eff = iStart ? PH0 : r_phase;
   assign w_rate_eff  = iStart ? w_rate_in : r_rate;

   assign w_taps = {iData, w_s_eff[0], w_s_eff[1], w_s_eff[2], w_s_eff[3], w_s_eff[4], w_s_eff[5]};
   assign w_a    = ^(G0 & w_taps);
   assign w_b    = ^(G1 & w_taps);

   always_comb begin
      w_s_nxt     = w_s_eff;
      w_phase_nxt = w_phase_eff;
      w_rate_nxt  = w_rate_eff;
      w_buf_nxt   = r_buf;
      w_cnt_nxt   = r_cnt;

      if (w_pop) begin
         w_buf_nxt = {1'b0, r_buf[1]};
         w_cnt_nxt = r_cnt - 2'd1;
      end

      if (w_accept) begin
         w_s_nxt = {w_s_eff[4:0], iData};
         // oReady guarantees the buffer is empty after this cycle's pop, so new bits land at the head
         case (w_phase_eff)
            PH1: begin
               w_buf_nxt = {1'b0, w_a};
               w_cnt_nxt = 2'd1;
            end
            PH2: begin
               w_buf_nxt = {1'b0, w_b};
               w_cnt_nxt = 2'd1;
            end
            default: begin
               w_buf_nxt = {w_b, w_a};
               w_cnt_nxt = 2'd2;
            end
         endcase

         case (w_rate_eff)
            RATE_2_3: w_phase_nxt = (w_phase_eff == PH0) ? PH1 : PH0;
            RATE_3_4: begin
               case (w_phase_eff)
                  PH0:     w_phase_nxt = PH1;
                  PH1:     w_phase_nxt = PH2;
                  default: w_phase_nxt = PH0;
               endcase
            end
            default:  w_phase_nxt = PH0;
         endcase
      end
   end

   always_ff @(posedge iClk) begin
      if (!iRst) begin
         r_s     <= '0;
         r_phase <= PH0;
         r_rate  <= RATE_1_2;
         r_buf   <= '0;
         r_cnt   <= '0;
      end else begin
         r_s     <= w_s_nxt;
         r_phase <= w_phase_nxt;
         r_rate  <= w_rate_nxt;
         r_buf   <= w_buf_nxt;
         r_cnt   <= w_cnt_nxt;
      end
   end

endmodule

// File: tb/tb_conv_punct_encoder.sv
// Bench for conv_punct_encoder: constant impulse-response tables plus a cycle-level
// reference model (unbounded queue of pending coded bits) checked every cycle.
module tb_conv_punct_encoder;

   logic       iClk = 1'b0;
   logic       iRst, iStart, iData, iValid, iReady;
   logic [1:0] iRate;
   logic       oReady, oData, oValid;

   always #5 iClk = ~iClk;

   conv_punct_encoder #(.G0(7'o133), .G1(7'o171)) dut (
      .iClk(iClk), .iRst(iRst), .iStart(iStart), .iRate(iRate),
      .iData(iData), .iValid(iValid), .oReady(oReady),
      .oData(oData), .oValid(oValid), .iReady(iReady)
   );

   int n_pass = 0;
   int n_total = 0;

   logic [5:0] m_s;
   logic [1:0] m_ph, m_rate;
   logic       m_q[$];
   logic       q_out[$];

   typedef struct {
      logic [1:0]  rate;
      logic        start_with_data;
      logic [6:0]  din;
      int          nout;
      logic [15:0] dout;
   } vec_t;

   vec_t tbl[5];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", name, act, exp);
   endtask

   // Coded bits from the octal generators: A taps current,s1,s2,s4,s5; B taps current,s0,s1,s2,s5
   function automatic logic gen_a(input logic b, input logic [5:0] s);
      return b ^ s[1] ^ s[2] ^ s[4] ^ s[5];
   endfunction

   function automatic logic gen_b(input logic b, input logic [5:0] s);
      return b ^ s[0] ^ s[1] ^ s[2] ^ s[5];
   endfunction

   task automatic cycle(input logic st, input logic [1:0] rt, input logic v, input logic d,
                        input logic rdy, output logic acc);
      logic exp_rdy, pop, a, b;
      iStart = st; iRate = rt; iValid = v; iData = d; iReady = rdy;
      #1;
      exp_rdy = (m_q.size() == 0) || (m_q.size() == 1 && rdy);
      check("oValid", 32'(oValid), 32'(m_q.size() != 0));
      check("oReady", 32'(oReady), 32'(exp_rdy));
      if (m_q.size() != 0) check("oData", 32'(oData), 32'(m_q[0]));
      acc = v & exp_rdy;
      pop = (m_q.size() != 0) && rdy;
      if (oValid && rdy) q_out.push_back(oData);
      if (pop) void'(m_q.pop_front());
      if (st) begin
         m_s = '0; m_ph = 2'd0; m_rate = rt;
      end
      if (acc) begin
         a = gen_a(d, m_s);
         b = gen_b(d, m_s);
         if (m_ph != 2'd2) m_q.push_back(a);
         if (m_ph != 2'd1) m_q.push_back(b);
         m_s = {m_s[4:0], d};
         if (m_rate == 2'd1)      m_ph = (m_ph == 2'd0) ? 2'd1 : 2'd0;
         else if (m_rate == 2'd2) m_ph = (m_ph == 2'd2) ? 2'd0 : m_ph + 2'd1;
         else                     m_ph = 2'd0;
      end
      @(posedge iClk);
      @(negedge iClk);
   endtask

   task automatic do_reset();
      iRst = 1'b0; iStart = 1'b0; iValid = 1'b0; iData = 1'b0; iReady = 1'b0; iRate = 2'b00;
      @(posedge iClk);
      @(negedge iClk);
      iRst = 1'b1;
      m_q.delete(); m_s = '0; m_ph = 2'd0; m_rate = 2'd0;
      #1;
      check("rst_oValid", 32'(oValid), 32'd0);
      check("rst_oReady", 32'(oReady), 32'd1);
      check("rst_oData",  32'(oData),  32'd0);
      @(negedge iClk);
   endtask

   // Feeds n bits MSB-first; iRate is scrambled on non-start cycles since it must be ignored
   task automatic feed(input logic [15:0] bits, input int n, input logic first_start,
                       input logic [1:0] rt, input bit rnd);
      int i, budget;
      logic acc, st, v, rdy;
      logic [1:0] r;
      i = 0; budget = 0; st = first_start;
      while (i < n && budget < 400) begin
         v   = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
         rdy = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
         r   = st ? rt : 2'($urandom);
         cycle(st, r, v, bits[n-1-i], rdy, acc);
         st = 1'b0;
         if (acc) i++;
         budget++;
      end
      check("feed_done", 32'(i), 32'(n));
   endtask

   task automatic drain();
      int budget;
      logic acc;
      budget = 0;
      while ((m_q.size() != 0 || oValid) && budget < 100) begin
         cycle(1'b0, 2'($urandom), 1'b0, 1'b0, 1'b1, acc);
         budget++;
      end
      check("drain_empty", 32'(oValid), 32'd0);
   endtask

   task automatic check_stream(input string name, input logic [15:0] exp, input int n);
      check({name, "_len"}, 32'(q_out.size()), 32'(n));
      for (int k = 0; k < n; k++)
         if (k < q_out.size()) check(name, 32'(q_out[k]), 32'(exp[n-1-k]));
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      logic acc;
      tbl[0] = '{2'b00, 1'b0, 7'b1000000, 14, 16'(14'b11011111001011)};
      tbl[1] = '{2'b10, 1'b1, 7'b1000000, 10, 16'(10'b1101110011)};
      tbl[2] = '{2'b01, 1'b0, 7'b1000000, 11, 16'(11'b11011100111)};
      tbl[3] = '{2'b11, 1'b1, 7'b1000000, 14, 16'(14'b11011111001011)};
      tbl[4] = '{2'b00, 1'b0, 7'b1100000, 14, 16'(14'b11101000111001)};

      do_reset();

      for (int t = 0; t < 5; t++) begin
         q_out.delete();
         if (!tbl[t].start_with_data) begin
            cycle(1'b1, tbl[t].rate, 1'b0, 1'b0, 1'b1, acc);
            feed(16'(tbl[t].din), 7, 1'b0, 2'b00, 1'b0);
         end else begin
            feed(16'(tbl[t].din), 7, 1'b1, tbl[t].rate, 1'b0);
         end
         drain();
         check_stream($sformatf("table%0d", t), tbl[t].dout, tbl[t].nout);
      end

      // iStart with a rate change while two coded bits are still buffered
      q_out.delete();
      cycle(1'b1, 2'b00, 1'b0, 1'b0, 1'b1, acc);
      cycle(1'b0, 2'b01, 1'b1, 1'b1, 1'b1, acc);
      cycle(1'b0, 2'b01, 1'b0, 1'b0, 1'b0, acc);
      cycle(1'b1, 2'b10, 1'b1, 1'b1, 1'b0, acc);
      check("start_blocked_acc", 32'(acc), 32'd0);
      feed(16'(7'b1000000), 7, 1'b0, 2'b00, 1'b0);
      drain();
      check_stream("restart", 16'(12'b111101110011), 12);

      // Reset mid-frame with coded bits pending
      cycle(1'b1, 2'b00, 1'b0, 1'b0, 1'b1, acc);
      feed(16'(3'b101), 3, 1'b0, 2'b00, 1'b0);
      check("pre_reset_valid", 32'(oValid), 32'd1);
      do_reset();
      q_out.delete();
      feed(16'(7'b1000000), 7, 1'b0, 2'b00, 1'b0);
      drain();
      check_stream("post_reset", tbl[0].dout, tbl[0].nout);

      // Random handshakes at each rate, checked cycle by cycle against the model
      for (int r = 0; r < 3; r++) begin
         cycle(1'b1, 2'(r), 1'b0, 1'b0, 1'b0, acc);
         feed(16'($urandom), 16, 1'b0, 2'b00, 1'b1);
         feed(16'($urandom), 16, 1'b0, 2'b00, 1'b1);
         drain();
      end

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
